instr_encoder: RTL and testbench

- Inverse of the core's instruction decoder. Accepts symbolic operations (opcode class plus register and immediate fields) over a valid/ready handshake.
- Emits 32-bit machine words in the decoder's format, each tagged with a sequential instruction-memory address.
- Sits between the test/boot program source and instruction memory; produces the word stream the decoder later consumes.

---
 rtl/instr_encoder.sv | 177 +++++++++++++++++
 tb/tb_instr_encoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Symbolic-op to machine-word encoder with sequential address tagging.
// Optional post-LW NOP padding is enabled by defining INSTR_ENCODER_LOAD_PAD_EN.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       PAD_NOPS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       count
);

  if (PAD_NOPS < 1 || PAD_NOPS > 7) begin : g_pad_nops_range
    $error("instr_encoder: PAD_NOPS must be in 1..7");
  end

  typedef enum logic {PASS, PAD} state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                err_q, err_d;
  logic [15:0]         count_q, count_d;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
  logic                lw_q, lw_d;
  logic [2:0]          pad_left_q, pad_left_d;
`endif

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        enc_lw;
  logic        accept;
  logic        out_hs;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    enc_lw    = 1'b0;
    case (in_op)
      4'd0: enc_word = {6'd2, in_rs, in_rt, in_rd, 5'd10, 6'd32};
      4'd1: enc_word = {6'd2, in_rs, in_rt, in_rd, 5'd10, 6'd34};
      4'd2: enc_word = {6'd2, in_rs, in_rt, in_rd, 5'd10, 6'd36};
      4'd3: enc_word = {6'd2, in_rs, in_rt, in_rd, 5'd10, 6'd37};
      4'd4: enc_word = {6'd2, in_rs, in_rt, in_rd, 5'd10, 6'd50};
      4'd5: begin
        enc_word = {6'd3, in_rs, in_rt, in_imm};
        enc_lw   = 1'b1;
      end
      4'd6: enc_word = {6'd4, in_rs, in_rt, in_imm};
      4'd7: enc_word = '0;
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENCODER_LOAD_PAD_EN
  // A pending LW blocks intake so its pad words can follow it directly.
  assign in_ready = (!out_valid_q || out_ready) && (state_q == PASS) && !clear
                    && !(out_valid_q && lw_q);
`else
  assign in_ready = (!out_valid_q || out_ready) && (state_q == PASS) && !clear;
`endif

  assign accept = in_valid && in_ready;
  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;
    count_d     = count_q;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
    lw_d        = lw_q;
    pad_left_d  = pad_left_q;
`endif
    if (clear) begin
      state_d     = PASS;
      out_valid_d = 1'b0;
      out_addr_d  = BASE_ADDR;
      err_d       = 1'b0;
      count_d     = '0;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
      lw_d        = 1'b0;
      pad_left_d  = '0;
`endif
    end else begin
      if (out_hs) begin
        out_addr_d  = out_addr_q + ADDR_W'(1);
        count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        out_valid_d = 1'b0;
      end
`ifdef INSTR_ENCODER_LOAD_PAD_EN
      if (state_q == PAD) begin
        if (out_hs) begin
          if (pad_left_q == 3'd1) begin
            state_d = PASS;
          end else begin
            pad_left_d  = pad_left_q - 3'd1;
            out_valid_d = 1'b1;
            out_instr_d = '0;
          end
        end
      end else if (out_hs && lw_q) begin
        state_d     = PAD;
        pad_left_d  = 3'(PAD_NOPS);
        out_valid_d = 1'b1;
        out_instr_d = '0;
        lw_d        = 1'b0;
      end
`endif
      if (accept) begin
        if (enc_legal) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_word;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
          lw_d        = enc_lw;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PASS;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      count_q     <= '0;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
      lw_q        <= 1'b0;
      pad_left_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      count_q     <= count_d;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
      lw_q        <= lw_d;
      pad_left_q  <= pad_left_d;
`endif
    end
  end

`ifndef INSTR_ENCODER_LOAD_PAD_EN
  logic unused_enc_lw;
  assign unused_enc_lw = enc_lw;
`endif

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, directed corner sequences and a
// randomized run checked against a transaction-queue reference model.
module tb_instr_encoder;
  localparam int unsigned PADN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [15:0] count;
  logic        s_in_ready, s_out_valid, s_err;
  logic [31:0] s_out_instr;
  logic [1:0]  s_out_addr;
  logic [15:0] s_count;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00), .PAD_NOPS(PADN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .count(count));

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'b00), .PAD_NOPS(PADN)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_addr(s_out_addr), .err(s_err), .count(s_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    in_valid = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
    in_valid = 1'b1;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  // Reference encoder built from the field layout with shifts and ORs.
  function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm);
    logic [31:0] regs;
    int f2;
    regs = (32'(rs) << 21) | (32'(rt) << 16);
    case (op)
      4'd0: f2 = 32;
      4'd1: f2 = 34;
      4'd2: f2 = 36;
      4'd3: f2 = 37;
      4'd4: f2 = 50;
      default: f2 = 0;
    endcase
    if (op <= 4'd4) return (32'd2 << 26) | regs | (32'(rd) << 11) | (32'd10 << 6) | 32'(f2);
    if (op == 4'd5) return (32'd3 << 26) | regs | 32'(imm);
    if (op == 4'd6) return (32'd4 << 26) | regs | 32'(imm);
    return 32'h0;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] exp_instr;
    logic        exp_legal;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    bit          lw;
    bit          pad;
  } ent_t;

  vec_t vecs[9];
  ent_t q[$];
  logic [15:0] m_cnt;
  int unsigned m_addr;
  logic m_err, m_rdy;
  logic [31:0] exp_w[4];

  initial begin
    vecs[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h08221AA0, 1'b1};
    vecs[1] = '{4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h08221AA2, 1'b1};
    vecs[2] = '{4'd2, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h08221AA4, 1'b1};
    vecs[3] = '{4'd3, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h08221AA5, 1'b1};
    vecs[4] = '{4'd4, 5'd1, 5'd1, 5'd2, 16'h0000, 32'h082112B2, 1'b1};
    vecs[5] = '{4'd5, 5'd4, 5'd5, 5'd0, 16'h0010, 32'h0C850010, 1'b1};
    vecs[6] = '{4'd6, 5'd4, 5'd5, 5'd0, 16'h0014, 32'h10850014, 1'b1};
    vecs[7] = '{4'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h00000000, 1'b1};
    vecs[8] = '{4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 32'h00000000, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Vector table: one request each from a cleared state
    for (int i = 0; i < 9; i++) begin
      do_clear();
      out_ready = 1'b1;
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
      #1;
      chk("vec_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("vec_out_valid", out_valid, 32'(vecs[i].exp_legal));
      if (vecs[i].exp_legal) chk("vec_out_instr", out_instr, vecs[i].exp_instr);
      chk("vec_out_addr", out_addr, 0);
      chk("vec_err", err, 32'(!vecs[i].exp_legal));
      tick();
      chk("vec_count", count, 32'(vecs[i].exp_legal));
      chk("vec_addr_after", out_addr, 32'(vecs[i].exp_legal));
    end

    // Stall with MUL pending; a further request must not be taken
    do_clear();
    out_ready = 1'b0;
    drive(4'd4, 5'd1, 5'd1, 5'd2, 16'h0);
    tick();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_instr", out_instr, 32'h082112B2);
      chk("stall_addr", out_addr, 0);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("stall_release_rdy", in_ready, 1);
    tick();
    chk("stall_drained", out_valid, 0);
    chk("stall_count", count, 1);
    chk("stall_addr_next", out_addr, 1);

    // Illegal op sets sticky err, emits nothing; clear restores
    do_clear();
    out_ready = 1'b1;
    drive(4'd12, 5'd0, 5'd0, 5'd0, 16'h0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("ill_err", err, 1);
    chk("ill_valid", out_valid, 0);
    chk("ill_count", count, 0);
    tick();
    chk("ill_err_sticky", err, 1);
    clear = 1'b1;
    #1;
    chk("clear_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    #1;
    chk("clear_err", err, 0);

    // Address wrap on the 2-bit instance
    do_clear();
    out_ready = 1'b1;
    drive(4'd7, 5'd0, 5'd0, 5'd0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("wrap_valid", s_out_valid, 1);
      chk("wrap_addr", s_out_addr, 32'(i % 4));
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_count", s_count, 5);
    chk("wrap_addr_wide", out_addr, 5);

    // Clear during a pending handshake drops it uncounted
    do_clear();
    out_ready = 1'b1;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clr_hs_count", count, 0);
    chk("clr_hs_addr", out_addr, 0);
    chk("clr_hs_valid", out_valid, 0);

`ifdef INSTR_ENCODER_LOAD_PAD_EN
    // LW followed by ADD: two pad words in between
    do_clear();
    out_ready = 1'b1;
    drive(4'd5, 5'd4, 5'd5, 5'd0, 16'h0010);
    tick();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    exp_w[0] = 32'h0C850010; exp_w[1] = 32'h0; exp_w[2] = 32'h0; exp_w[3] = 32'h08221AA0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pad_valid", out_valid, 1);
      chk("pad_instr", out_instr, exp_w[k]);
      chk("pad_addr", out_addr, 32'(k));
      chk("pad_in_ready", in_ready, 0);
      tick();
    end
    #1;
    chk("pad_done_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("pad_add_instr", out_instr, exp_w[3]);
    chk("pad_add_addr", out_addr, 3);
`endif

    // Randomized run against the transaction-queue model
    do_clear();
    q.delete();
    m_cnt = '0; m_addr = 0; m_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_imm = 16'($urandom);
      #1;
      m_rdy = !clear && (q.size() == 0 || (out_ready && !q[0].lw && !q[0].pad));
      chk("rnd_in_ready", in_ready, 32'(m_rdy));
      chk("rnd_s_in_ready", s_in_ready, 32'(m_rdy));
      if (clear) begin
        q.delete();
        m_cnt = '0; m_addr = 0; m_err = 1'b0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          void'(q.pop_front());
          m_addr++;
          if (m_cnt != 16'hFFFF) m_cnt++;
        end
        if (in_valid && m_rdy) begin
          if (in_op > 4'd7) m_err = 1'b1;
`ifdef INSTR_ENCODER_LOAD_PAD_EN
          else if (in_op == 4'd5) begin
            q.push_back('{ref_word(in_op, in_rs, in_rt, in_rd, in_imm), 1'b1, 1'b0});
            for (int p = 0; p < int'(PADN); p++) q.push_back('{32'h0, 1'b0, 1'b1});
          end
`endif
          else q.push_back('{ref_word(in_op, in_rs, in_rt, in_rd, in_imm), 1'b0, 1'b0});
        end
      end
      tick();
      #1;
      chk("rnd_valid", out_valid, 32'(q.size() != 0));
      chk("rnd_s_valid", s_out_valid, 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_instr", out_instr, q[0].w);
        chk("rnd_s_instr", s_out_instr, q[0].w);
      end
      chk("rnd_addr", out_addr, 32'(m_addr[7:0]));
      chk("rnd_s_addr", s_out_addr, 32'(m_addr[1:0]));
      chk("rnd_count", count, 32'(m_cnt));
      chk("rnd_s_count", s_count, 32'(m_cnt));
      chk("rnd_err", err, 32'(m_err));
    end

    // Asynchronous reset mid-cycle
    in_valid = 1'b0;
    clear = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_addr", out_addr, 0);
    chk("arst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
